// File: rtl/rx_word_register_pkg.sv
// ----------------------------------------------------------------------------
// rx_word_register_pkg
// Shared definitions for the receive-side word register: the default byte
// width and the two-state pairing machine encoding.
// ----------------------------------------------------------------------------
package rx_word_register_pkg;

    localparam int DATA_W = 8;

    // WAIT_HI: waiting for the first (upper) byte of a pair.
    // WAIT_LO: upper byte held, waiting for the second (lower) byte.
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

endpackage : rx_word_register_pkg

// File: rtl/rx_word_register_edge.sv
// ----------------------------------------------------------------------------
// rising_edge_detect
// One-bit registered rising-edge detector.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset; clears the history flop
//   sig_in  - level input to watch
//   sig_q   - sig_in delayed by one clock
//   rise    - combinational pulse, high while sig_in=1 and sig_q=0
// ----------------------------------------------------------------------------
module rising_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_q,
    output logic rise
);

    logic sig_d;
    logic hist_q;

    always_comb begin
        sig_d = sig_in;
    end

    // Clearing the history on reset means a level that is already high when
    // reset releases still produces exactly one rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sig_d;
        end
    end

    assign sig_q = hist_q;
    assign rise  = sig_in & ~hist_q;

endmodule : rising_edge_detect

// File: rtl/rx_word_register.sv
// ----------------------------------------------------------------------------
// rx_word_register
// Pairs consecutive error-free bytes from the UART receiver into a word.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   data_in    - received byte, sampled only on an accept event
//   valid      - byte strobe; a rising edge is one accept event
//   PERROR     - parity error for the byte at the accept event
//   FERROR     - framing error for the byte at the accept event
//   out        - last completed word {first byte, second byte}
//   word_valid - one-cycle pulse in the cycle out takes a new word
//   err        - a byte was dropped since the last completed word
// ----------------------------------------------------------------------------
module rx_word_register
    import rx_word_register_pkg::*;
#(
    parameter int                    DATA_W   = rx_word_register_pkg::DATA_W,
    parameter logic [2*DATA_W-1:0]   OUT_INIT = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  valid,
    input  logic                  PERROR,
    input  logic                  FERROR,
    output logic [2*DATA_W-1:0]   out,
    output logic                  word_valid,
    output logic                  err
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [2*DATA_W-1:0] out_q, out_d;
    logic                word_valid_q, word_valid_d;
    logic                err_q, err_d;
    logic                valid_q;
    logic                accept;

    rising_edge_detect u_valid_edge (
        .clk    (clk),
        .rst_n  (reset),
        .sig_in (valid),
        .sig_q  (valid_q),
        .rise   (accept)
    );

    // Error flags only matter at an accept; a bad byte always restarts the
    // pair from WAIT_HI and throws away any held upper byte.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        out_d        = out_q;
        word_valid_d = 1'b0;
        err_d        = err_q;
        if (accept) begin
            if (PERROR || FERROR) begin
                hold_d  = '0;
                err_d   = 1'b1;
                state_d = WAIT_HI;
            end else begin
                case (state_q)
                    WAIT_HI: begin
                        hold_d  = data_in;
                        state_d = WAIT_LO;
                    end
                    WAIT_LO: begin
                        out_d        = {hold_q, data_in};
                        word_valid_d = 1'b1;
                        err_d        = 1'b0;
                        state_d      = WAIT_HI;
                    end
                    default: begin
                        state_d = WAIT_HI;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_HI;
            hold_q       <= '0;
            out_q        <= OUT_INIT;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            out_q        <= out_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
        end
    end

    assign out        = out_q;
    assign word_valid = word_valid_q;
    assign err        = err_q;

endmodule : rx_word_register

// File: tb/tb_rx_word_register.sv
// ----------------------------------------------------------------------------
// tb_rx_word_register
// Directed self-checking bench for rx_word_register. Inputs change on the
// falling edge; outputs are checked on the falling edge, half a cycle after
// the rising edge that updates them.
// ----------------------------------------------------------------------------
module tb_rx_word_register;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid;
    logic        PERROR;
    logic        FERROR;
    logic [15:0] out;
    logic        word_valid;
    logic        err;

    int tests_run;
    int tests_failed;

    rx_word_register #(
        .DATA_W   (8),
        .OUT_INIT (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid      (valid),
        .PERROR     (PERROR),
        .FERROR     (FERROR),
        .out        (out),
        .word_valid (word_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one byte with a single-cycle valid pulse; returns at the falling
    // edge after the accepting rising edge, with valid low again.
    task automatic apply_stimulus(input logic [7:0] d, input logic perr,
                                  input logic ferr);
        @(negedge clk);
        data_in = d;
        valid   = 1'b1;
        PERROR  = perr;
        FERROR  = ferr;
        @(negedge clk);
        valid   = 1'b0;
        PERROR  = 1'b0;
        FERROR  = 1'b0;
        data_in = 8'h00;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        data_in = 8'h00;
        valid   = 1'b0;
        PERROR  = 1'b0;
        FERROR  = 1'b0;

        // Reset held for 400 ns.
        #400;
        check_output("rst_out", out, 16'h0000);
        check_output("rst_wv", {15'd0, word_valid}, 16'd0);
        check_output("rst_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_out", out, 16'h0000);

        // Error flags with no valid edge do nothing.
        PERROR = 1'b1;
        repeat (5) @(negedge clk);
        PERROR = 1'b0;
        check_output("perr_idle_out", out, 16'h0000);
        check_output("perr_idle_err", {15'd0, err}, 16'd0);

        // Basic pair E3/FF.
        apply_stimulus(8'hE3, 1'b0, 1'b0);
        check_output("half_wv", {15'd0, word_valid}, 16'd0);
        check_output("half_out", out, 16'h0000);
        apply_stimulus(8'hFF, 1'b0, 1'b0);
        check_output("e3ff_out", out, 16'hE3FF);
        check_output("e3ff_wv", {15'd0, word_valid}, 16'd1);
        check_output("e3ff_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        check_output("e3ff_wv_drop", {15'd0, word_valid}, 16'd0);
        check_output("e3ff_hold", out, 16'hE3FF);

        // valid held high three cycles counts once.
        data_in = 8'hA5;
        valid   = 1'b1;
        repeat (3) @(negedge clk);
        valid   = 1'b0;
        check_output("held_wv", {15'd0, word_valid}, 16'd0);
        check_output("held_out", out, 16'hE3FF);
        @(negedge clk);
        apply_stimulus(8'h5A, 1'b0, 1'b0);
        check_output("a55a_out", out, 16'hA55A);
        check_output("a55a_wv", {15'd0, word_valid}, 16'd1);

        // Framing error on the second byte drops the pair.
        apply_stimulus(8'h12, 1'b0, 1'b0);
        apply_stimulus(8'h34, 1'b0, 1'b1);
        check_output("ferr_err", {15'd0, err}, 16'd1);
        check_output("ferr_out", out, 16'hA55A);
        check_output("ferr_wv", {15'd0, word_valid}, 16'd0);
        apply_stimulus(8'h56, 1'b0, 1'b0);
        check_output("ferr_err_hold", {15'd0, err}, 16'd1);
        check_output("ferr_56_out", out, 16'hA55A);
        apply_stimulus(8'h78, 1'b0, 1'b0);
        check_output("5678_out", out, 16'h5678);
        check_output("5678_err", {15'd0, err}, 16'd0);
        check_output("5678_wv", {15'd0, word_valid}, 16'd1);

        // Parity error on an upper byte restarts pairing.
        apply_stimulus(8'h9A, 1'b1, 1'b0);
        check_output("perr_err", {15'd0, err}, 16'd1);
        apply_stimulus(8'hBC, 1'b0, 1'b0);
        apply_stimulus(8'hDE, 1'b0, 1'b0);
        check_output("bcde_out", out, 16'hBCDE);
        check_output("bcde_err", {15'd0, err}, 16'd0);

        // Reset mid-pair loses the held byte.
        apply_stimulus(8'h11, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_out", out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(8'h22, 1'b0, 1'b0);
        check_output("mid_rst_half", out, 16'h0000);
        apply_stimulus(8'h33, 1'b0, 1'b0);
        check_output("2233_out", out, 16'h2233);
        check_output("2233_wv", {15'd0, word_valid}, 16'd1);

        // valid held high across reset release gives one accept.
        @(negedge clk);
        reset   = 1'b0;
        data_in = 8'h44;
        valid   = 1'b1;
        @(negedge clk);
        reset   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        apply_stimulus(8'h55, 1'b0, 1'b0);
        check_output("4455_out", out, 16'h4455);
        check_output("4455_wv", {15'd0, word_valid}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rx_word_register

// File: doc/rx_word_register.md
Name: rx_word_register

Overview:
- Receive-side output register of the transmitter/receiver system.
- Collects consecutive error-free bytes from the UART receiver on `valid` strobes and pairs them into a 16-bit word on `out`.
- A byte flagged with a parity error (`PERROR`) or framing error (`FERROR`) is discarded and the pairing restarts.
- `out` holds the last good word until a new pair completes.

Parameters:
- DATA_W, 8, width of one received byte; `out` is 2*DATA_W wide.
- OUT_INIT, 16'h0000, value loaded into `out` on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- data_in  in  DATA_W  received byte; sampled only when an accept event occurs.
- valid  in  1  byte-available strobe from the receiver; may be held high for several cycles.
- PERROR  in  1  parity error for the current byte; meaningful only at an accept event.
- FERROR  in  1  framing error for the current byte; meaningful only at an accept event.
- out  out  2*DATA_W  last completed word: first byte in [15:8], second byte in [7:0].
- word_valid  out  1  one-cycle pulse when `out` is updated.
- err  out  1  set when a byte is dropped for PERROR/FERROR; cleared when the next word completes.

Behaviour:
- Reset (reset=0, async): `out`=OUT_INIT, `word_valid`=0, `err`=0, state=WAIT_HI, `valid_q`=0, hold byte=0.
- Edge detect: `valid_q` is `valid` registered. Accept event = `valid` & ~`valid_q`. Holding `valid` high yields exactly one accept. A new accept requires `valid` to return low for at least one cycle.
- `PERROR`/`FERROR` are ignored when there is no accept event (e.g. `PERROR`=1 while `valid`=0 has no effect).
- State WAIT_HI, on a good accept (no error): latch `data_in` into the hold byte and go to WAIT_LO.
- State WAIT_LO, on a good accept:
  - `out` <= {hold byte, `data_in`}, `word_valid`=1 for that cycle, `err`<=0.
  - Go to WAIT_HI.
  - `out` is visible the cycle after the clock edge that detects the accept (1-cycle latency).
- Bad accept (`PERROR` | `FERROR`) in either state:
  - Byte dropped, hold byte discarded.
  - `err`<=1; `out` unchanged; `word_valid`=0.
  - State goes to WAIT_HI.
- `word_valid` is 0 in all other cycles. `out` never changes except on word completion or reset.
- `data_in` X/unchanged outside accept events has no effect.
- Reset mid-pair: partial byte is lost and the pair restarts at WAIT_HI.
- Reset while `valid` is held high: `valid_q`=0 after release, so a still-high `valid` produces one accept on the first clock after reset release.

Decomposition:
- Shared package: DATA_W constant, state typedef {WAIT_HI, WAIT_LO}.
- One natural sub-module, rising_edge_detect: a 1-bit registered edge detector with the same async active-low reset, used for `valid`.

Test Plan:
- Reset held 400 ns, then released -> `out`=16'h0000, `word_valid`=0, `err`=0.
- `PERROR`=1 with `valid`=0 for several cycles -> no state change, `out`=16'h0000, `err`=0.
- `data_in`=8'hE3 with `valid` pulse (no errors), then `data_in`=8'hFF with `valid` pulse -> one cycle after the second accept: `out`=16'hE3FF, `word_valid` one-cycle pulse, `err`=0.
- `valid` held high 3 cycles with `data_in`=8'hA5, then low, then 8'h5A pulse -> `out`=16'hA55A (held `valid` counted once).
- Good byte 8'h12, then 8'h34 with `FERROR`=1, then pairs 8'h56/8'h78 -> `err`=1 after the bad byte, `out` unchanged; then `out`=16'h5678 and `err`=0.
- Reset asserted after the first byte 8'h11 of a pair, then released, then pairs 8'h22/8'h33 -> `out`=16'h2233 (8'h11 lost).
